// File: rtl/class_hvec_search_pkg.sv
// ----------------------------------------------------------------------------
// class_hvec_pkg
// Shared widths and the search FSM state type for the class-hypervector
// associative search. Every file of the block imports this package, so the
// widths are defined in one place only.
// ----------------------------------------------------------------------------
package class_hvec_pkg;

   localparam int DI_PARALLEL_W_BITS = 64;   // frame width in bits
   localparam int NUM_CLASSES        = 8;    // stored class hypervectors
   localparam int NUM_FRAMES         = 3;    // frames per hypervector
   localparam int CLASS_W            = $clog2(NUM_CLASSES);
   localparam int FRAME_W            = 2;
   // Wide enough for the worst-case distance NUM_FRAMES*W (all bits differ).
   localparam int DIST_W             = $clog2(NUM_FRAMES*DI_PARALLEL_W_BITS+1);

   typedef enum logic [1:0] {
      LOAD   = 2'd0,
      SEARCH = 2'd1,
      DONE   = 2'd2
   } search_state_t;

endpackage

// File: rtl/class_hvec_search_if.sv
// ----------------------------------------------------------------------------
// class_hvec_search_if
// Query input stream and result output stream of the associative search.
//   query_valid / query_ready / query_frame : query frames, in order 0..N-1
//   result_valid / result_ready             : result handshake
//   result_class / result_dist              : winning class and its distance
// The slave modport is the search block; the master modport is whatever
// feeds queries and consumes results.
// ----------------------------------------------------------------------------
interface class_hvec_search_if
   import class_hvec_pkg::*;
();

   logic                          query_valid;
   logic                          query_ready;
   logic [DI_PARALLEL_W_BITS-1:0] query_frame;
   logic                          result_valid;
   logic                          result_ready;
   logic [CLASS_W-1:0]            result_class;
   logic [DIST_W-1:0]             result_dist;

   modport master (
      output query_valid, query_frame, result_ready,
      input  query_ready, result_valid, result_class, result_dist
   );

   modport slave (
      input  query_valid, query_frame, result_ready,
      output query_ready, result_valid, result_class, result_dist
   );

endinterface

// File: rtl/class_hvec_search_popcount.sv
// ----------------------------------------------------------------------------
// hvec_popcount
// Combinational population count built as a balanced adder tree: the vector
// is split in two halves, each half is counted by a smaller instance of this
// module, and the two partial counts are added.
//   vec : input vector, WIDTH bits
//   cnt : number of ones in vec, $clog2(WIDTH+1) bits
// ----------------------------------------------------------------------------
module hvec_popcount #(
   parameter int WIDTH = 64,
   parameter int OUT_W = $clog2(WIDTH+1)
) (
   input  logic [WIDTH-1:0] vec,
   output logic [OUT_W-1:0] cnt
);

   generate
      if (WIDTH == 1) begin : g_leaf
         assign cnt = vec;
      end else begin : g_split
         localparam int LO_W  = WIDTH / 2;
         localparam int HI_W  = WIDTH - LO_W;
         localparam int LO_OW = $clog2(LO_W+1);
         localparam int HI_OW = $clog2(HI_W+1);

         logic [LO_OW-1:0] cnt_lo;
         logic [HI_OW-1:0] cnt_hi;

         hvec_popcount #(.WIDTH(LO_W)) u_lo (
            .vec (vec[LO_W-1:0]),
            .cnt (cnt_lo)
         );

         hvec_popcount #(.WIDTH(HI_W)) u_hi (
            .vec (vec[WIDTH-1:LO_W]),
            .cnt (cnt_hi)
         );

         // Both halves are zero-extended to the output width; the sum never
         // exceeds WIDTH, so OUT_W bits always hold it.
         assign cnt = OUT_W'(cnt_lo) + OUT_W'(cnt_hi);
      end
   endgenerate

endmodule

// File: rtl/class_hvec_search.sv
// ----------------------------------------------------------------------------
// class_hvec_search
// Classifies a query hypervector against the stored class hypervectors.
// The query is buffered frame by frame, then the class ROM is walked one
// (class, frame) pair per cycle while per-class Hamming distances are
// accumulated; the class with the smallest distance is returned (lowest
// index wins on a tie).
//   clk, rst_n       : clock, synchronous active-low reset
//   bus (slave)      : query frame stream in, result stream out
//   rom_frame_id     : class address to the class-vector ROM
//   rom_frame_index  : frame address to the class-vector ROM
//   rom_class_vec    : ROM data, combinational from the address
//   busy             : high while searching or holding a result
// ----------------------------------------------------------------------------
module class_hvec_search
   import class_hvec_pkg::*;
(
   input  logic                          clk,
   input  logic                          rst_n,
   class_hvec_search_if.slave            bus,
   output logic [CLASS_W-1:0]            rom_frame_id,
   output logic [FRAME_W-1:0]            rom_frame_index,
   input  logic [DI_PARALLEL_W_BITS-1:0] rom_class_vec,
   output logic                          busy
);

   localparam int PC_W = $clog2(DI_PARALLEL_W_BITS+1);

   search_state_t                 state_reg;
   logic [FRAME_W-1:0]            load_cnt_reg;
   logic [FRAME_W-1:0]            frame_cnt_reg;
   logic [CLASS_W-1:0]            class_cnt_reg;
   logic [DIST_W-1:0]             acc_reg;
   logic [DIST_W-1:0]             best_dist_reg;
   logic [CLASS_W-1:0]            best_class_reg;
   logic                          result_valid_reg;
   logic                          busy_reg;
   logic [DI_PARALLEL_W_BITS-1:0] qbuf [NUM_FRAMES];

   logic                          load_hs;
   logic [DI_PARALLEL_W_BITS-1:0] diff;
   logic [PC_W-1:0]               pc;
   logic [DIST_W-1:0]             dist_next;
   logic                          last_frame;
   logic                          last_class;

   // Ready is gated by rst_n so nothing is accepted while reset is held.
   assign bus.query_ready = rst_n && (state_reg == LOAD);
   assign load_hs         = bus.query_valid && bus.query_ready;

   assign rom_frame_id    = class_cnt_reg;
   assign rom_frame_index = frame_cnt_reg;

   assign diff = qbuf[frame_cnt_reg] ^ rom_class_vec;

   hvec_popcount #(.WIDTH(DI_PARALLEL_W_BITS)) u_popcount (
      .vec (diff),
      .cnt (pc)
   );

   // Running distance including the current frame; frame 0 restarts the sum,
   // so the accumulator never needs an explicit clear between classes.
   assign dist_next  = ((frame_cnt_reg == '0) ? '0 : acc_reg) + DIST_W'(pc);
   assign last_frame = (frame_cnt_reg == FRAME_W'(NUM_FRAMES-1));
   assign last_class = (class_cnt_reg == CLASS_W'(NUM_CLASSES-1));

   assign bus.result_valid = result_valid_reg;
   assign bus.result_class = best_class_reg;
   assign bus.result_dist  = best_dist_reg;
   assign busy             = busy_reg;

   // Query buffer: plain data storage, no reset needed.
   always_ff @(posedge clk) begin
      if (load_hs) begin
         qbuf[load_cnt_reg] <= bus.query_frame;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg        <= LOAD;
         load_cnt_reg     <= '0;
         frame_cnt_reg    <= '0;
         class_cnt_reg    <= '0;
         acc_reg          <= '0;
         best_dist_reg    <= '0;
         best_class_reg   <= '0;
         result_valid_reg <= 1'b0;
         busy_reg         <= 1'b0;
      end else begin
         case (state_reg)
            LOAD: begin
               if (load_hs) begin
                  if (load_cnt_reg == FRAME_W'(NUM_FRAMES-1)) begin
                     state_reg     <= SEARCH;
                     busy_reg      <= 1'b1;
                     load_cnt_reg  <= '0;
                     frame_cnt_reg <= '0;
                     class_cnt_reg <= '0;
                  end else begin
                     load_cnt_reg <= load_cnt_reg + 1'b1;
                  end
               end
            end

            SEARCH: begin
               acc_reg <= dist_next;
               if (last_frame) begin
                  frame_cnt_reg <= '0;
                  // Strict less-than keeps the earlier (lower) class on a tie.
                  if ((class_cnt_reg == '0) || (dist_next < best_dist_reg)) begin
                     best_dist_reg  <= dist_next;
                     best_class_reg <= class_cnt_reg;
                  end
                  if (last_class) begin
                     class_cnt_reg    <= '0;
                     state_reg        <= DONE;
                     result_valid_reg <= 1'b1;
                  end else begin
                     class_cnt_reg <= class_cnt_reg + 1'b1;
                  end
               end else begin
                  frame_cnt_reg <= frame_cnt_reg + 1'b1;
               end
            end

            DONE: begin
               if (bus.result_ready) begin
                  state_reg        <= LOAD;
                  result_valid_reg <= 1'b0;
                  busy_reg         <= 1'b0;
                  load_cnt_reg     <= '0;
               end
            end

            default: begin
               state_reg        <= LOAD;
               result_valid_reg <= 1'b0;
               busy_reg         <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/class_hvec_search.md
# class_hvec_search

Associative-search block that classifies a query hypervector against the stored class hypervectors. It buffers a query arriving as `NUM_FRAMES` frames of `DI_PARALLEL_W_BITS` bits over a valid/ready stream. It then walks the class-vector ROM (`class_hvec_gen`) by driving its `frame_id`/`frame_index` address and accumulates the per-class Hamming distance. It returns the class index with minimum distance. It sits after the encoder in the inference path and is the reader side of the class-vector ROM.

## Interface
Parameters:
- `DI_PARALLEL_W_BITS`, 64, frame width in bits.
- `NUM_CLASSES`, 8, number of classes.
- `NUM_FRAMES`, 3, frames per hypervector.
- `CLASS_W`, 3, class index width, equal to $clog2(NUM_CLASSES).
- `FRAME_W`, 2, frame index width.
- `DIST_W`, 8, distance width, equal to $clog2(NUM_FRAMES*DI_PARALLEL_W_BITS+1).

Ports:
- `clk`  in  1  sole clock; all logic on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `query_valid`  in  1  query frame valid.
- `query_ready`  out  1  block accepts a query frame.
- `query_frame`  in  DI_PARALLEL_W_BITS  query frame data; frames arrive in order 0..NUM_FRAMES-1.
- `rom_frame_id`  out  CLASS_W  class address to the ROM.
- `rom_frame_index`  out  FRAME_W  frame address to the ROM.
- `rom_class_vec`  in  DI_PARALLEL_W_BITS  ROM data; combinational from the address, same cycle.
- `result_valid`  out  1  result available.
- `result_ready`  in  1  consumer accepts the result.
- `result_class`  out  CLASS_W  winning class.
- `result_dist`  out  DIST_W  Hamming distance of the winning class.
- `busy`  out  1  high in SEARCH or DONE.

## Operation
- FSM states: LOAD, SEARCH, DONE. Reset state is LOAD.
- LOAD:
  - `query_ready` = 1.
  - Each handshake (`query_valid && query_ready`) stores `query_frame` into `qbuf[load_cnt]` and increments `load_cnt`.
  - A handshake at `load_cnt == NUM_FRAMES-1` moves the FSM to SEARCH and clears the class and frame counters.
- SEARCH, one (class, frame) pair per cycle:
  - `rom_frame_id` = class counter and `rom_frame_index` = frame counter, both driven straight from the counters.
  - `pc` = popcount(`qbuf[f] ^ rom_class_vec`).
  - `acc` <= (f==0 ? 0 : acc) + pc.
  - At f == NUM_FRAMES-1, `d = acc + pc` (or just `pc` when NUM_FRAMES==1). The best register is replaced when this is the first class or `d < best_dist` (strict less-than). The frame counter wraps to 0 and the class counter increments.
  - At the last class and last frame, the FSM moves to DONE.
- DONE:
  - `result_valid` = 1.
  - `result_class` and `result_dist` are held stable until `result_ready`.
  - The handshake returns the FSM to LOAD and clears `load_cnt`.
- Tie rule: on equal distance the lowest class index wins.
- Arithmetic:
  - popcount is DI_PARALLEL_W_BITS wide into $clog2(W+1) bits, zero-extended to DIST_W.
  - The accumulator cannot overflow, since max = NUM_FRAMES*W = 192 < 256.
- `query_frame` is ignored outside LOAD. `result_ready` is ignored outside DONE.

## Timing
- Reset values (rst_n low at a clock edge):
  - state=LOAD, all counters 0, `result_valid`=0, `result_class`=0, `result_dist`=0, `busy`=0, `rom_frame_id`=0, `rom_frame_index`=0.
  - `query_ready` is gated by `rst_n` and reads 0 while `rst_n` is low.
- Latency: the last query frame is accepted at edge T. SEARCH occupies cycles T+1..T+NUM_CLASSES*NUM_FRAMES (24 by default). `result_valid` rises at T+25.
- Throughput: one query per NUM_FRAMES + 24 + 1 cycles minimum. The next query frame can be accepted in the cycle after the result handshake.
- Gaps in `query_valid` stall LOAD without losing data.
- Reset mid-LOAD, mid-SEARCH or in DONE discards the partial query or result. The next cycle is LOAD with `result_valid`=0.

## Structure
- Package `class_hvec_pkg` holds:
  - DI_PARALLEL_W_BITS, NUM_CLASSES, NUM_FRAMES, CLASS_W, FRAME_W and DIST_W localparams;
  - the `search_state_t` enum {LOAD, SEARCH, DONE}.
- Sub-module `hvec_popcount`: a combinational adder-tree popcount, parameterised by width.
- The ROM (`class_hvec_gen`) is instantiated by the parent and is not inside this block.

## Test plan
Unless noted, tests use a bench stub ROM where class c, frame f = (1<<(8c))-1, giving 8c ones per frame.
- Query all-zero, 3 frames back-to-back -> `result_class`=0, `result_dist`=0, `result_valid` exactly 25 cycles after the last frame handshake.
- Query all-ones -> `result_class`=7, `result_dist`=24 (192-24*7).
- Real `class_hvec_gen` ROM, query = class 3 frames 0..2 -> `result_class`=3, `result_dist`=0.
- Tie: stub where classes 2 and 5 both equal the query, others differ -> `result_class`=2, `result_dist`=0.
- Backpressure: `result_ready` low for 10 cycles in DONE -> `result_class`/`result_dist` stable and `query_ready`=0 throughout. One idle cycle between query frames gives an identical result.
- Reset: `rst_n` low at SEARCH cycle 10 -> next cycle state LOAD, `result_valid`=0, `busy`=0. A fresh all-zero query then gives class 0, dist 0.
